tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of one dvi_tx TMDS channel: takes 10-bit parallel symbols (post-deserializer),

---
 rtl/tmds_channel_decoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel decoder: recovers word alignment from control-token runs, requests
// deserializer bitslips while searching, and decodes symbols to pixel byte, C0/C1 and DE.
module tmds_channel_decoder #(
    parameter int LOCK_THRESHOLD  = 16,
    parameter int SEARCH_WINDOW   = 4096,
    parameter int BITSLIP_HOLDOFF = 16,
    parameter int MAX_DATA_RUN    = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ce,
    input  logic [9:0] i_symbol,
    output logic [7:0] o_data,
    output logic       o_c0,
    output logic       o_c1,
    output logic       o_de,
    output logic       o_aligned,
    output logic       o_bitslip
);

    localparam int CRW = $clog2(LOCK_THRESHOLD + 1);
    localparam int SWW = $clog2(SEARCH_WINDOW + 1);
    localparam int HOW = $clog2(BITSLIP_HOLDOFF + 1);
    localparam int DRW = $clog2(MAX_DATA_RUN + 1);

    localparam logic [CRW-1:0] CR_TERM = CRW'(LOCK_THRESHOLD);
    localparam logic [SWW-1:0] SW_TERM = SWW'(SEARCH_WINDOW);
    localparam logic [HOW-1:0] HO_TERM = HOW'(BITSLIP_HOLDOFF);
    localparam logic [DRW-1:0] DR_TERM = DRW'(MAX_DATA_RUN);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_HOLDOFF = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    function automatic logic is_token(input logic [9:0] s);
        case (s)
            TOK_C00, TOK_C01, TOK_C10, TOK_C11: is_token = 1'b1;
            default:                            is_token = 1'b0;
        endcase
    endfunction

    // Returns {c1, c0} carried by a control token.
    function automatic logic [1:0] token_ctrl(input logic [9:0] s);
        case (s)
            TOK_C00: token_ctrl = 2'b00;
            TOK_C01: token_ctrl = 2'b01;
            TOK_C10: token_ctrl = 2'b10;
            TOK_C11: token_ctrl = 2'b11;
            default: token_ctrl = 2'b00;
        endcase
    endfunction

    // Undo the optional inversion (bit 9) and the XOR/XNOR transition chain (bit 8).
    function automatic logic [7:0] decode_data(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] q;
        d    = s[9] ? ~s[7:0] : s[7:0];
        q    = 8'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        decode_data = q;
    endfunction

    logic [9:0]     r_sym;
    logic           r_s1_vld;
    logic [1:0]     r_state;
    logic [CRW-1:0] r_ctrl_run;
    logic [SWW-1:0] r_search_cnt;
    logic [HOW-1:0] r_hold_cnt;
    logic [DRW-1:0] r_data_run;
    logic [7:0]     r_data;
    logic           r_c0;
    logic           r_c1;
    logic           r_de;
    logic           r_aligned;
    logic           r_bitslip;

    logic           w_tok;
    logic [1:0]     w_tok_c;
    logic [CRW-1:0] w_ctrl_inc;
    logic [SWW-1:0] w_search_inc;
    logic [HOW-1:0] w_hold_inc;
    logic [DRW-1:0] w_data_inc;

    logic [1:0]     w_state_nxt;
    logic [CRW-1:0] w_ctrl_nxt;
    logic [SWW-1:0] w_search_nxt;
    logic [HOW-1:0] w_hold_nxt;
    logic [DRW-1:0] w_data_run_nxt;
    logic           w_slip_nxt;
    logic           w_aligned_nxt;
    logic [7:0]     w_data_nxt;
    logic           w_c0_nxt;
    logic           w_c1_nxt;
    logic           w_de_nxt;
    logic           w_advance;

    assign w_tok     = is_token(r_sym);
    assign w_tok_c   = token_ctrl(r_sym);
    assign w_advance = i_ce & r_s1_vld;

    assign w_ctrl_inc   = (r_ctrl_run   == CR_TERM) ? r_ctrl_run   : r_ctrl_run   + CRW'(1);
    assign w_search_inc = (r_search_cnt == SW_TERM) ? r_search_cnt : r_search_cnt + SWW'(1);
    assign w_hold_inc   = (r_hold_cnt   == HO_TERM) ? r_hold_cnt   : r_hold_cnt   + HOW'(1);
    assign w_data_inc   = (r_data_run   == DR_TERM) ? r_data_run   : r_data_run   + DRW'(1);

    // Alignment FSM: next state, counters and bitslip request for the stage-1 symbol.
    always_comb begin
        w_state_nxt    = r_state;
        w_ctrl_nxt     = r_ctrl_run;
        w_search_nxt   = r_search_cnt;
        w_hold_nxt     = r_hold_cnt;
        w_data_run_nxt = r_data_run;
        w_slip_nxt     = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                w_ctrl_nxt   = w_tok ? w_ctrl_inc : {CRW{1'b0}};
                w_search_nxt = w_search_inc;
                if (w_ctrl_nxt == CR_TERM) begin
                    w_state_nxt    = ST_LOCKED;
                    w_ctrl_nxt     = {CRW{1'b0}};
                    w_search_nxt   = {SWW{1'b0}};
                    w_data_run_nxt = {DRW{1'b0}};
                end else if (w_search_nxt == SW_TERM) begin
                    w_state_nxt  = ST_HOLDOFF;
                    w_slip_nxt   = 1'b1;
                    w_ctrl_nxt   = {CRW{1'b0}};
                    w_search_nxt = {SWW{1'b0}};
                    w_hold_nxt   = {HOW{1'b0}};
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_HOLDOFF: begin
                w_hold_nxt = w_hold_inc;
                if (w_hold_nxt == HO_TERM) begin
                    w_state_nxt  = ST_SEARCH;
                    w_hold_nxt   = {HOW{1'b0}};
                    w_ctrl_nxt   = {CRW{1'b0}};
                    w_search_nxt = {SWW{1'b0}};
                end else begin
                    w_state_nxt = ST_HOLDOFF;
                end
            end
            ST_LOCKED: begin
                w_data_run_nxt = w_tok ? {DRW{1'b0}} : w_data_inc;
                if (w_data_run_nxt == DR_TERM) begin
                    w_state_nxt    = ST_SEARCH;
                    w_data_run_nxt = {DRW{1'b0}};
                    w_ctrl_nxt     = {CRW{1'b0}};
                    w_search_nxt   = {SWW{1'b0}};
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt    = ST_SEARCH;
                w_ctrl_nxt     = {CRW{1'b0}};
                w_search_nxt   = {SWW{1'b0}};
                w_hold_nxt     = {HOW{1'b0}};
                w_data_run_nxt = {DRW{1'b0}};
            end
        endcase
    end

    // Output gating uses the post-update lock state so lock/loss show on the deciding symbol.
    always_comb begin
        w_aligned_nxt = (w_state_nxt == ST_LOCKED);
        w_data_nxt    = 8'd0;
        w_c0_nxt      = r_c0;
        w_c1_nxt      = r_c1;
        w_de_nxt      = 1'b0;
        if (!w_aligned_nxt) begin
            w_c0_nxt = 1'b0;
            w_c1_nxt = 1'b0;
        end else if (w_tok) begin
            w_c0_nxt = w_tok_c[0];
            w_c1_nxt = w_tok_c[1];
        end else begin
            w_de_nxt   = 1'b1;
            w_data_nxt = decode_data(r_sym);
        end
    end

    // Stage 1: capture the incoming symbol and mark it valid for the decoder.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sym    <= 10'd0;
            r_s1_vld <= 1'b0;
        end else if (i_ce) begin
            r_sym    <= i_symbol;
            r_s1_vld <= 1'b1;
        end
    end

    // Stage 2: FSM state, counters and registered decoded outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_SEARCH;
            r_ctrl_run   <= {CRW{1'b0}};
            r_search_cnt <= {SWW{1'b0}};
            r_hold_cnt   <= {HOW{1'b0}};
            r_data_run   <= {DRW{1'b0}};
            r_data       <= 8'd0;
            r_c0         <= 1'b0;
            r_c1         <= 1'b0;
            r_de         <= 1'b0;
            r_aligned    <= 1'b0;
        end else if (w_advance) begin
            r_state      <= w_state_nxt;
            r_ctrl_run   <= w_ctrl_nxt;
            r_search_cnt <= w_search_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_data_run   <= w_data_run_nxt;
            r_data       <= w_data_nxt;
            r_c0         <= w_c0_nxt;
            r_c1         <= w_c1_nxt;
            r_de         <= w_de_nxt;
            r_aligned    <= w_aligned_nxt;
        end
    end

    // Bitslip is a one-clock pulse regardless of ce on the following clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitslip <= 1'b0;
        end else begin
            r_bitslip <= w_advance & w_slip_nxt;
        end
    end

    assign o_data    = r_data;
    assign o_c0      = r_c0;
    assign o_c1      = r_c1;
    assign o_de      = r_de;
    assign o_aligned = r_aligned;
    assign o_bitslip = r_bitslip;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: a reference model predicts every decoded output,
// and an independent monitor compares each DUT output slot against the queued prediction.
module tb_tmds_channel_decoder;

    typedef struct packed {
        logic [7:0] data;
        logic       c0;
        logic       c1;
        logic       de;
        logic       aligned;
        logic       bitslip;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [9:0] sym = 10'd0;
    logic [7:0] o_data;
    logic       o_c0, o_c1, o_de, o_aligned, o_bitslip;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    logic [9:0] tok_tbl [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference model state (plain integers, modes as small ints)
    int         m_mode;   // 0 = hunting, 1 = settling after slip, 2 = locked
    int         m_run, m_win, m_hold, m_drun;
    logic [1:0] m_c;

    tmds_channel_decoder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ce      (ce),
        .i_symbol  (sym),
        .o_data    (o_data),
        .o_c0      (o_c0),
        .o_c1      (o_c1),
        .o_de      (o_de),
        .o_aligned (o_aligned),
        .o_bitslip (o_bitslip)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a = '{data: o_data, c0: o_c0, c1: o_c1, de: o_de, aligned: o_aligned, bitslip: o_bitslip};
        return a;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t: actual data=%h c1c0=%b%b de=%b al=%b bs=%b, required data=%h c1c0=%b%b de=%b al=%b bs=%b",
                     name, $time, act.data, act.c1, act.c0, act.de, act.aligned, act.bitslip,
                     req.data, req.c1, req.c0, req.de, req.aligned, req.bitslip);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_win = 0; m_hold = 0; m_drun = 0; m_c = 2'b00;
    endtask

    task automatic model_step(input logic [9:0] s, output exp_t e);
        int   idx;
        bit   slip;
        logic [7:0] d;
        idx  = -1;
        slip = 1'b0;
        for (int k = 0; k < 4; k++) if (tok_tbl[k] == s) idx = k;
        case (m_mode)
            0: begin
                m_run = (idx >= 0) ? m_run + 1 : 0;
                m_win = m_win + 1;
                if (m_run >= 16) begin
                    m_mode = 2; m_drun = 0;
                end else if (m_win >= 4096) begin
                    slip = 1'b1; m_mode = 1; m_hold = 0; m_run = 0; m_win = 0;
                end
            end
            1: begin
                m_hold = m_hold + 1;
                if (m_hold >= 16) begin
                    m_mode = 0; m_run = 0; m_win = 0;
                end
            end
            default: begin
                m_drun = (idx >= 0) ? 0 : m_drun + 1;
                if (m_drun >= 2048) begin
                    m_mode = 0; m_run = 0; m_win = 0;
                end
            end
        endcase
        e = '0;
        e.bitslip = slip;
        if (m_mode != 2) begin
            m_c = 2'b00;
        end else if (idx >= 0) begin
            e.aligned = 1'b1;
            m_c = 2'(idx);
        end else begin
            e.aligned = 1'b1;
            e.de = 1'b1;
            d = s[9] ? ~s[7:0] : s[7:0];
            for (int i = 0; i < 8; i++)
                e.data[i] = (i == 0) ? d[0] : (d[i] ^ d[i-1] ^ ~s[8]);
        end
        e.c0 = m_c[0];
        e.c1 = m_c[1];
    endtask

    task automatic drive(input logic ce_v, input logic [9:0] s);
        exp_t e;
        @(negedge clk);
        ce  = ce_v;
        sym = s;
        if (ce_v) begin
            model_step(s, e);
            sb_q.push_back(e);
        end
    endtask

    function automatic logic [9:0] rand_sym();
        if ($urandom_range(0, 3) == 0) return tok_tbl[$urandom_range(0, 3)];
        return 10'($urandom);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        ce = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", actual(), '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: an output slot occurs on each ce edge once stage 1 holds a symbol; otherwise outputs hold.
    initial begin : monitor
        exp_t last, e;
        logic ce_s;
        bit   s1;
        last = '0;
        s1   = 1'b0;
        forever begin
            @(posedge clk);
            ce_s = ce;
            #1;
            if (!rst_n) begin
                s1 = 1'b0;
                sb_q.delete();
                last = '0;
            end else begin
                if (ce_s && s1) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow t=%0t: actual output slot with empty queue, required a prediction", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("output", actual(), e);
                        last = e;
                        last.bitslip = 1'b0;
                    end
                end else begin
                    check("hold", actual(), last);
                end
                if (ce_s) s1 = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        model_reset();
        #1 check("reset_state", actual(), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Lock on 16 tokens, then data decode and a control token
        repeat (16) drive(1'b1, 10'b1101010100);
        drive(1'b1, 10'h100);
        drive(1'b1, 10'h3FF);
        drive(1'b1, 10'b1010101011);

        // Random locked traffic with random ce
        repeat (300) drive(1'($urandom_range(0, 3) != 0), rand_sym());

        // ce low for 5 clocks while the symbol changes
        repeat (5) drive(1'b0, 10'($urandom));

        // Lock loss after a long data run, then relock
        drive(1'b1, 10'b0101010100);
        repeat (2048) drive(1'b1, 10'h100);
        repeat (20) drive(1'b1, tok_tbl[$urandom_range(0, 3)]);
        repeat (10) drive(1'b1, 10'($urandom));

        // Reset mid-line while locked; relock needs 16 fresh tokens
        apply_reset();
        repeat (15) drive(1'b1, 10'b0010101011);
        drive(1'b1, 10'h1A5);
        repeat (16) drive(1'b1, 10'b0010101011);
        repeat (20) drive(1'b1, rand_sym());

        // Bitslip after a full window of non-tokens, then holdoff and renewed search
        apply_reset();
        repeat (4096) drive(1'b1, 10'h100);
        repeat (30) drive(1'b1, 10'h100);
        repeat (200) drive(1'($urandom_range(0, 1)), rand_sym());

        repeat (3) drive(1'b0, 10'd0);
        n_checks++;
        if (sb_q.size() != 1) begin
            n_fail++;
            $display("FAIL sb_drain: actual %0d pending predictions, required 1", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
